draw_objects_n: RTL and testbench
=================================

# draw_objects_n

Parametrised successor to the single-circle overlay stage. It draws up to N_OBJ filled circles (puck, mallets, markers) over the incoming VGA stream in one pipelined pass, with per-object colour, radius and enable. Object positions are latched frame-coherently at the start of vertical blanking, so objects never tear mid-frame. Per-object overlap flags are reported once per frame for game logic. It sits between `draw_background` and the output register stage, on the pixel clock.

## Interface
Parameters:
- N_OBJ, 3, number of objects; 1..8; index 0 has highest draw priority
- COORD_W, 12, width of hcount/vcount and object coordinates
- RAD_W, 8, width of each object radius

Ports:
- clk_in  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in, vcount_in  in  COORD_W  pixel counters from upstream
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  upstream timing
- rgb_in  in  12  upstream pixel, {r,g,b} 4 bits each
- obj_xpos, obj_ypos  in  N_OBJ*COORD_W  object centres, object i at [i*COORD_W +: COORD_W]
- obj_radius  in  N_OBJ*RAD_W  radius in pixels
- obj_rgb  in  N_OBJ*12  object colour
- obj_en  in  N_OBJ  object visible when 1
- hcount_out, vcount_out  out  COORD_W  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing
- rgb_out  out  12  composed pixel
- overlap_out  out  N_OBJ  bit i: object i shared at least one visible pixel with another object during the previous frame
- frame_strobe  out  1  one-cycle pulse when shadow registers and overlap_out update

## Operation
- Frame edge: vblnk_in=1 while registered vblnk_prev=0. On that cycle, copy obj_xpos/ypos/radius/rgb/en into shadow registers, set overlap_out to the accumulator, clear the accumulator, and raise frame_strobe for one cycle on the next edge.
- Between frame edges, object inputs are ignored; drawing uses shadow values only.
- Stage 1: dx_i = hcount - x_i, dy_i = vcount - y_i, signed COORD_W+1 bits. Register the timing and rgb_in.
- Stage 2: dx_i², dy_i² (unsigned 2*COORD_W+2 bits), r_i² (2*RAD_W bits). Register all.
- Stage 3: hit_i = en_i && (dx_i² + dy_i² <= r_i²), compared in full width with no truncation. rgb_out = obj_rgb of the lowest-index hit; otherwise the delayed rgb_in.
- Blanking: if the delayed hblnk or vblnk is 1, rgb_out = 12'h000 and no hits are accumulated.
- Overlap accumulation: for each visible pixel where two or more hit_i are 1, OR those hit bits into the accumulator.
- Radius 0 draws exactly the centre pixel. Objects partly or fully off-screen are clipped naturally, with no wrap-around, because the arithmetic is signed.
- Reset: all shadow registers, pipeline registers, accumulator and outputs go to 0. vblnk_prev resets to 1, so the first frame edge after reset is the first 0→1 transition of vblnk_in.

## Timing
- Latency is exactly 3 clk_in cycles, and is identical for every *_out signal and rgb_out.
- Shadow values take effect for the pixel entering stage 1 on the cycle after the frame edge.
- overlap_out and frame_strobe change in the cycle after the frame edge and hold for one full frame.
- Simultaneous accumulate and frame-edge clear: the clear wins for the old bits. A hit from that cycle lands in the new accumulator.
- Asserting rst mid-frame clears state on the next edge. Outputs stay 0 until the pipeline refills (3 cycles); overlap_out stays 0 until the second frame edge after reset.

## Test plan
- Single object: N_OBJ=3, object 0 at (400,300), r=10, rgb 12'hF00, others disabled. Pixel (410,300) → F00; (411,300) → rgb_in; (407,307) → F00 (49+49≤100); rgb_out appears 3 cycles after its input pixel.
- Priority and overlap: object 0 at (100,100) r=20 F00; object 1 at (110,100) r=20 0F0. Pixel (105,100) → F00; (125,100) → 0F0. After the next frame edge, overlap_out=3'b011 and frame_strobe pulses once.
- Frame coherence: change obj_xpos 0 from 100 to 500 mid-active-area. The rest of the frame still draws at 100; the next frame draws at 500.
- Clipping and radius 0: object at (0,0) r=5 → pixels (0..5,0) coloured, no colour at (1023,0). r=0 at (50,50) → only (50,50) coloured.
- Blanking: object covering pixel (1030,10) while hblnk_in=1 → rgb_out=000 and no overlap recorded.
- Reset mid-frame: assert rst for 1 cycle during the active area → next cycle all outputs 0, overlap_out=0. Normal drawing resumes after 3 cycles using the reset shadow values (all disabled) until the next frame edge.

Source files
------------

// File: rtl/draw_objects_n.sv
// Overlays up to N_OBJ filled circles on the VGA stream in a 3-stage pipeline,
// with frame-coherent object shadows and per-frame overlap reporting.
module draw_objects_n #(
  parameter int unsigned N_OBJ   = 3,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned RAD_W   = 8
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       hcount_in,
  input  logic [COORD_W-1:0]       vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [11:0]              rgb_in,
  input  logic [N_OBJ*COORD_W-1:0] obj_xpos,
  input  logic [N_OBJ*COORD_W-1:0] obj_ypos,
  input  logic [N_OBJ*RAD_W-1:0]   obj_radius,
  input  logic [N_OBJ*12-1:0]      obj_rgb,
  input  logic [N_OBJ-1:0]         obj_en,
  output logic [COORD_W-1:0]       hcount_out,
  output logic [COORD_W-1:0]       vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [11:0]              rgb_out,
  output logic [N_OBJ-1:0]         overlap_out,
  output logic                     frame_strobe
);

  localparam int unsigned D_W   = COORD_W + 1;
  localparam int unsigned SQ_W  = 2 * COORD_W + 2;
  localparam int unsigned R2_W  = 2 * RAD_W;
  localparam int unsigned SUM_W = (SQ_W + 1 > R2_W) ? SQ_W + 1 : R2_W;

  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [11:0]        rgb;
  } pix_t;

  // Shadow copies of the object inputs, refreshed only at the frame edge
  logic [N_OBJ*COORD_W-1:0] sh_xpos;
  logic [N_OBJ*COORD_W-1:0] sh_ypos;
  logic [N_OBJ*RAD_W-1:0]   sh_radius;
  logic [N_OBJ*12-1:0]      sh_rgb;
  logic [N_OBJ-1:0]         sh_en;
  logic                     vblnk_prev;
  logic [N_OBJ-1:0]         acc;

  pix_t               pix_c;
  pix_t               s1_pix;
  pix_t               s2_pix;
  logic [N_OBJ*12-1:0] s1_rgbo;
  logic [N_OBJ*12-1:0] s2_rgbo;
  logic [N_OBJ-1:0]    s1_en;
  logic [N_OBJ-1:0]    s2_en;

  logic                frame_edge_c;
  logic [N_OBJ-1:0]    hit_c;
  logic                visible_c;
  logic                multi_c;
  logic [N_OBJ-1:0]    acc_add_c;
  logic [11:0]         sel_rgb_c;

  assign frame_edge_c = vblnk_in & ~vblnk_prev;

  always_comb begin
    pix_c        = '0;
    pix_c.hcount = hcount_in;
    pix_c.vcount = vcount_in;
    pix_c.hsync  = hsync_in;
    pix_c.vsync  = vsync_in;
    pix_c.hblnk  = hblnk_in;
    pix_c.vblnk  = vblnk_in;
    pix_c.rgb    = rgb_in;
  end

  // Per-object distance arithmetic: signed deltas, then squares against r^2
  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    logic signed [D_W-1:0] dx_c;
    logic signed [D_W-1:0] dy_c;
    logic        [D_W-1:0] ax_c;
    logic        [D_W-1:0] ay_c;
    logic signed [D_W-1:0] s1_dx;
    logic signed [D_W-1:0] s1_dy;
    logic        [RAD_W-1:0] s1_rad;
    logic        [SQ_W-1:0]  s2_dx2;
    logic        [SQ_W-1:0]  s2_dy2;
    logic        [R2_W-1:0]  s2_r2;

    assign dx_c = D_W'({1'b0, hcount_in}) - D_W'({1'b0, sh_xpos[g*COORD_W +: COORD_W]});
    assign dy_c = D_W'({1'b0, vcount_in}) - D_W'({1'b0, sh_ypos[g*COORD_W +: COORD_W]});
    // Magnitude fits unsigned in D_W bits even for the most negative delta
    assign ax_c = s1_dx[D_W-1] ? D_W'(-s1_dx) : D_W'(s1_dx);
    assign ay_c = s1_dy[D_W-1] ? D_W'(-s1_dy) : D_W'(s1_dy);

    always_ff @(posedge clk_in) begin
      if (rst) begin
        s1_dx  <= '0;
        s1_dy  <= '0;
        s1_rad <= '0;
        s2_dx2 <= '0;
        s2_dy2 <= '0;
        s2_r2  <= '0;
      end else begin
        s1_dx  <= dx_c;
        s1_dy  <= dy_c;
        s1_rad <= sh_radius[g*RAD_W +: RAD_W];
        s2_dx2 <= SQ_W'(ax_c) * SQ_W'(ax_c);
        s2_dy2 <= SQ_W'(ay_c) * SQ_W'(ay_c);
        s2_r2  <= R2_W'(s1_rad) * R2_W'(s1_rad);
      end
    end

    assign hit_c[g] = s2_en[g] &&
                      ((SUM_W'(s2_dx2) + SUM_W'(s2_dy2)) <= SUM_W'(s2_r2));
  end

  // Timing and per-object colour/enable travel with the pixel
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_pix  <= '0;
      s2_pix  <= '0;
      s1_rgbo <= '0;
      s2_rgbo <= '0;
      s1_en   <= '0;
      s2_en   <= '0;
    end else begin
      s1_pix  <= pix_c;
      s2_pix  <= s1_pix;
      s1_rgbo <= sh_rgb;
      s2_rgbo <= s1_rgbo;
      s1_en   <= sh_en;
      s2_en   <= s1_en;
    end
  end

  // Lowest-index hit wins; blanking forces black and suppresses accumulation
  always_comb begin
    sel_rgb_c = s2_pix.rgb;
    for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        sel_rgb_c = s2_rgbo[i*12 +: 12];
      end
    end
  end

  assign visible_c = ~s2_pix.hblnk & ~s2_pix.vblnk;
  assign multi_c   = (hit_c & (hit_c - N_OBJ'(1))) != '0;
  assign acc_add_c = (visible_c && multi_c) ? hit_c : '0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s2_pix.hcount;
      vcount_out <= s2_pix.vcount;
      hsync_out  <= s2_pix.hsync;
      vsync_out  <= s2_pix.vsync;
      hblnk_out  <= s2_pix.hblnk;
      vblnk_out  <= s2_pix.vblnk;
      rgb_out    <= visible_c ? sel_rgb_c : 12'h000;
    end
  end

  // Frame edge: latch shadows, publish and restart the overlap accumulator
  always_ff @(posedge clk_in) begin
    if (rst) begin
      vblnk_prev   <= 1'b1;
      sh_xpos      <= '0;
      sh_ypos      <= '0;
      sh_radius    <= '0;
      sh_rgb       <= '0;
      sh_en        <= '0;
      acc          <= '0;
      overlap_out  <= '0;
      frame_strobe <= 1'b0;
    end else begin
      vblnk_prev   <= vblnk_in;
      frame_strobe <= frame_edge_c;
      if (frame_edge_c) begin
        sh_xpos     <= obj_xpos;
        sh_ypos     <= obj_ypos;
        sh_radius   <= obj_radius;
        sh_rgb      <= obj_rgb;
        sh_en       <= obj_en;
        overlap_out <= acc;
        acc         <= acc_add_c;
      end else begin
        acc <= acc | acc_add_c;
      end
    end
  end

endmodule

// File: tb/tb_draw_objects_n.sv
// Scoreboard bench for draw_objects_n: a reference circle model predicts each
// pixel and the per-frame overlap flags; DUT outputs are collected and compared.
module tb_draw_objects_n;

  localparam int N  = 3;
  localparam int CW = 12;
  localparam int RW = 8;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [CW-1:0] hcount_in, vcount_in;
  logic          hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]   rgb_in;
  logic [N*CW-1:0] obj_xpos, obj_ypos;
  logic [N*RW-1:0] obj_radius;
  logic [N*12-1:0] obj_rgb;
  logic [N-1:0]    obj_en;
  logic [CW-1:0] hcount_out, vcount_out;
  logic          hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]   rgb_out;
  logic [N-1:0]  overlap_out;
  logic          frame_strobe;

  draw_objects_n #(.N_OBJ(N), .COORD_W(CW), .RAD_W(RW)) dut (
    .clk_in(clk_in), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .obj_xpos(obj_xpos), .obj_ypos(obj_ypos), .obj_radius(obj_radius),
    .obj_rgb(obj_rgb), .obj_en(obj_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .overlap_out(overlap_out), .frame_strobe(frame_strobe)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int h; int v; bit hb; int rgb; } px_t;
  typedef struct { int rgb; int h; } res_t;

  // Object inputs as driven, and the bench's own copy of what should be latched
  int ox[N], oy[N], orad[N], orgb[N];
  bit oen[N];
  int sx[N], sy[N], sr[N], srgb[N];
  bit sen[N];

  px_t  stim_q[$];
  res_t exp_q[$];
  res_t obs_q[$];
  int   acc_m;
  int   exp_ovl, obs_ovl, strobe_cnt;
  int   tests = 0;
  int   fails = 0;

  always_comb begin
    obj_xpos = '0; obj_ypos = '0; obj_radius = '0; obj_rgb = '0; obj_en = '0;
    for (int i = 0; i < N; i++) begin
      obj_xpos[i*CW +: CW]   = CW'(ox[i]);
      obj_ypos[i*CW +: CW]   = CW'(oy[i]);
      obj_radius[i*RW +: RW] = RW'(orad[i]);
      obj_rgb[i*12 +: 12]    = 12'(orgb[i]);
      obj_en[i]              = oen[i];
    end
  end

  function automatic void model(input px_t p, output int rgb, output int hits);
    int dx, dy;
    hits = 0;
    rgb  = p.rgb;
    if (p.hb) begin
      rgb = 0;
      return;
    end
    for (int i = N - 1; i >= 0; i--) begin
      dx = p.h - sx[i];
      dy = p.v - sy[i];
      if (sen[i] && (dx * dx + dy * dy <= sr[i] * sr[i])) begin
        hits = hits | (1 << i);
        rgb  = srgb[i];
      end
    end
  endfunction

  task automatic px(input int h, input int v, input bit hb, input int rgb);
    px_t p;
    p.h = h; p.v = v; p.hb = hb; p.rgb = rgb;
    stim_q.push_back(p);
  endtask

  task automatic clear_objs();
    for (int i = 0; i < N; i++) begin
      ox[i] = 0; oy[i] = 0; orad[i] = 0; orgb[i] = 0; oen[i] = 1'b0;
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int r, input int c);
    ox[i] = x; oy[i] = y; orad[i] = r; orgb[i] = c; oen[i] = 1'b1;
  endtask

  // Drives queued pixels back to back; expectations pushed as driven, outputs collected 3 cycles on
  task automatic run_stream();
    int   n;
    int   erg, hits;
    px_t  p;
    res_t e, o;
    n = stim_q.size();
    for (int c = 0; c < n + 3; c++) begin
      @(negedge clk_in);
      if (c >= 3) begin
        o.rgb = int'(rgb_out);
        o.h   = int'(hcount_out);
        obs_q.push_back(o);
      end
      if (c < n) begin
        p = stim_q[c];
        hcount_in = CW'(p.h);
        vcount_in = CW'(p.v);
        hblnk_in  = p.hb;
        vblnk_in  = 1'b0;
        rgb_in    = 12'(p.rgb);
        model(p, erg, hits);
        e.rgb = erg;
        e.h   = p.h;
        exp_q.push_back(e);
        if (!p.hb && $countones(hits) >= 2) acc_m = acc_m | hits;
      end else begin
        hblnk_in  = 1'b1;
        hcount_in = '0;
        vcount_in = '0;
      end
    end
    stim_q.delete();
  endtask

  // Raises vblnk_in from 0 and records the strobe count and published overlap
  task automatic frame_edge();
    @(negedge clk_in);
    hblnk_in = 1'b1;
    vblnk_in = 1'b0;
    @(negedge clk_in);
    vblnk_in = 1'b1;
    exp_ovl  = acc_m;
    acc_m    = 0;
    for (int i = 0; i < N; i++) begin
      sx[i] = ox[i]; sy[i] = oy[i]; sr[i] = orad[i]; srgb[i] = orgb[i]; sen[i] = oen[i];
    end
    strobe_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      if (frame_strobe) strobe_cnt++;
      if (k == 0) obs_ovl = int'(overlap_out);
    end
    vblnk_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b1; vblnk_in = 1'b0; rgb_in = 12'hABC;
    clear_objs();
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sr[i] = 0; srgb[i] = 0; sen[i] = 1'b0;
    end
    acc_m = 0;
    repeat (3) @(negedge clk_in);
    tests++;
    if (rgb_out !== 12'h000 || hcount_out !== '0 || vcount_out !== '0) begin
      fails++;
      $display("FAIL reset_pixel: rgb_out=%h hcount_out=%0d vcount_out=%0d, required 000/0/0",
               rgb_out, hcount_out, vcount_out);
    end
    tests++;
    if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_timing: sync/blank=%b, required 0000",
               {hsync_out, vsync_out, hblnk_out, vblnk_out});
    end
    tests++;
    if (overlap_out !== '0 || frame_strobe !== 1'b0) begin
      fails++;
      $display("FAIL reset_frame: overlap_out=%b frame_strobe=%b, required 000/0",
               overlap_out, frame_strobe);
    end
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic test_single();
    res_t e, o;
    bit   first = 1'b1;
    clear_objs();
    set_obj(0, 400, 300, 10, 12'hF00);
    frame_edge();
    tests++;
    if (strobe_cnt !== 1 || obs_ovl !== exp_ovl) begin
      fails++;
      $display("FAIL single_edge: strobes=%0d overlap=%0d, required 1/%0d", strobe_cnt, obs_ovl, exp_ovl);
    end
    px(410, 300, 0, 12'h123); px(411, 300, 0, 12'h123); px(407, 307, 0, 12'h456);
    px(408, 307, 0, 12'h456); px(400, 290, 0, 12'h111); px(400, 289, 0, 12'h111);
    px(400, 300, 0, 12'h222); px(390, 300, 0, 12'h333);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h || (first && o.rgb !== 12'hF00)) begin
        fails++;
        $display("FAIL single_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
      first = 1'b0;
    end
  endtask

  task automatic test_priority();
    res_t e, o;
    clear_objs();
    set_obj(0, 100, 100, 20, 12'hF00);
    set_obj(1, 110, 100, 20, 12'h0F0);
    frame_edge();
    px(105, 100, 0, 12'h00F);
    px(125, 100, 0, 12'h00F);
    for (int h = 75; h <= 135; h++) px(h, 100, 0, 12'h00F);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        $display("FAIL priority_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
    frame_edge();
    tests++;
    if (obs_ovl !== exp_ovl || obs_ovl !== 3 || strobe_cnt !== 1) begin
      fails++;
      $display("FAIL priority_overlap: overlap=%0d strobes=%0d, required 3/1", obs_ovl, strobe_cnt);
    end
  endtask

  task automatic test_frame_coherence();
    res_t e, o;
    ox[0] = 500;
    px(100, 100, 0, 12'h00F); px(500, 100, 0, 12'h00F); px(90, 100, 0, 12'h00F);
    run_stream();
    frame_edge();
    tests++;
    if (obs_ovl !== exp_ovl) begin
      fails++;
      $display("FAIL coherence_overlap: overlap=%0d, required %0d", obs_ovl, exp_ovl);
    end
    px(500, 100, 0, 12'h00F); px(100, 100, 0, 12'h00F); px(480, 100, 0, 12'h00F);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        $display("FAIL coherence_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
  endtask

  task automatic test_clip_radius0();
    res_t e, o;
    clear_objs();
    set_obj(0, 0, 0, 5, 12'hF00);
    set_obj(1, 50, 50, 0, 12'h0F0);
    frame_edge();
    for (int h = 0; h <= 6; h++) px(h, 0, 0, 12'h555);
    px(1023, 0, 0, 12'h555); px(4095, 0, 0, 12'h555); px(0, 4095, 0, 12'h555);
    px(50, 50, 0, 12'h555); px(51, 50, 0, 12'h555); px(50, 49, 0, 12'h555); px(49, 51, 0, 12'h555);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        $display("FAIL clip_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
  endtask

  task automatic test_blanking();
    res_t e, o;
    clear_objs();
    set_obj(0, 1030, 10, 5, 12'hF00);
    set_obj(1, 1031, 10, 5, 12'h0F0);
    frame_edge();
    for (int h = 1028; h <= 1033; h++) px(h, 10, 1, 12'hEEE);
    px(1020, 10, 0, 12'hEEE);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        $display("FAIL blank_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
    frame_edge();
    tests++;
    if (obs_ovl !== exp_ovl || obs_ovl !== 0) begin
      fails++;
      $display("FAIL blank_overlap: overlap=%0d, required 0", obs_ovl);
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int   bad = 0;
    for (int i = 0; i < N; i++) begin
      set_obj(i, $urandom_range(20, 120), $urandom_range(20, 120),
              $urandom_range(0, 40), $urandom_range(1, 4095));
      oen[i] = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    frame_edge();
    for (int k = 0; k < 250; k++)
      px($urandom_range(0, 140), $urandom_range(0, 140), ($urandom_range(0, 7) == 0),
         $urandom_range(0, 4095));
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        bad++;
        if (bad < 10)
          $display("FAIL b2b_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                   e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
    frame_edge();
    tests++;
    if (obs_ovl !== exp_ovl || strobe_cnt !== 1) begin
      fails++;
      $display("FAIL b2b_overlap: overlap=%0d strobes=%0d, required %0d/1", obs_ovl, strobe_cnt, exp_ovl);
    end
  endtask

  task automatic test_reset_mid();
    res_t e, o;
    clear_objs();
    set_obj(0, 60, 60, 30, 12'hF00);
    set_obj(1, 70, 60, 30, 12'h0F0);
    frame_edge();
    for (int h = 40; h <= 90; h++) px(h, 60, 0, 12'h321);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
    end
    @(negedge clk_in);
    rst = 1'b1;
    hblnk_in = 1'b0; hcount_in = CW'(60); vcount_in = CW'(60); rgb_in = 12'h777;
    @(negedge clk_in);
    tests++;
    if (rgb_out !== 12'h000 || hcount_out !== '0 || overlap_out !== '0 || frame_strobe !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear: rgb_out=%h hcount_out=%0d overlap=%b strobe=%b, required 000/0/000/0",
               rgb_out, hcount_out, overlap_out, frame_strobe);
    end
    rst = 1'b0;
    acc_m = 0;
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sr[i] = 0; srgb[i] = 0; sen[i] = 1'b0;
    end
    px(60, 60, 0, 12'h777); px(70, 60, 0, 12'h777); px(65, 60, 0, 12'h777);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h || o.rgb !== 12'h777) begin
        fails++;
        $display("FAIL midreset_px h=%0d: rgb_out=%h hcount_out=%0d, required rgb %h hcount %0d",
                 e.h, o.rgb, o.h, e.rgb, e.h);
      end
    end
    frame_edge();
    tests++;
    if (obs_ovl !== 0 || strobe_cnt !== 1) begin
      fails++;
      $display("FAIL midreset_edge1: overlap=%0d strobes=%0d, required 0/1", obs_ovl, strobe_cnt);
    end
    px(65, 60, 0, 12'h777);
    run_stream();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests++;
      if (o.rgb !== e.rgb || o.h !== e.h) begin
        fails++;
        $display("FAIL midreset_redraw h=%0d: rgb_out=%h, required %h", e.h, o.rgb, e.rgb);
      end
    end
    frame_edge();
    tests++;
    if (obs_ovl !== exp_ovl || obs_ovl !== 3) begin
      fails++;
      $display("FAIL midreset_edge2: overlap=%0d, required 3", obs_ovl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_frame_coherence();
    test_clip_radius0();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
